// File: rtl/fpna_pkg.sv
// rtl/fpna_pkg.sv - shared defaults and config-word layout for the FPNA neuron cell
package fpna_pkg;

  localparam int DEF_N_IN    = 4;
  localparam int DEF_W_WIDTH = 4;
  localparam int DEF_V_WIDTH = 8;

  localparam int LEAK_W   = 3;
  localparam int REFRAC_W = 2;

  // Word layout, LSB first: weights, threshold, leak, refractory length
  localparam int W_LSB      = 0;
  localparam int THR_LSB    = W_LSB + DEF_N_IN * DEF_W_WIDTH;
  localparam int LEAK_LSB   = THR_LSB + DEF_V_WIDTH;
  localparam int REFRAC_LSB = LEAK_LSB + LEAK_W;
  localparam int CFG_LEN    = REFRAC_LSB + REFRAC_W;

endpackage

// File: rtl/fpna_cfg_chain.sv
// rtl/fpna_cfg_chain.sv - cfg_en-gated serial config shift register segment
module fpna_cfg_chain #(
  parameter int LEN = fpna_pkg::CFG_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_en,
  input  logic           cfg_in,
  output logic [LEN-1:0] cfg_word,
  output logic           cfg_out
);

  logic [LEN-1:0] cfg_sr;

  // New bits enter at the top so the first bit shifted lands in bit 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_sr <= '0;
    end else if (cfg_en) begin
      cfg_sr <= {cfg_in, cfg_sr[LEN-1:1]};
    end
  end

  assign cfg_word = cfg_sr;
  assign cfg_out  = cfg_sr[0];

endmodule

// File: rtl/fpna_neuron_cell.sv
// rtl/fpna_neuron_cell.sv - leaky integrate-and-fire neuron with serial config segment
module fpna_neuron_cell
  import fpna_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int W_WIDTH = DEF_W_WIDTH,
  parameter int V_WIDTH = DEF_V_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               cfg_en,
  input  logic               cfg_in,
  output logic               cfg_out,
  input  logic [N_IN-1:0]    spike_in,
  output logic               spike_out,
  output logic [V_WIDTH-1:0] v_mem
);

  localparam int THR_OFF    = N_IN * W_WIDTH;
  localparam int LEAK_OFF   = THR_OFF + V_WIDTH;
  localparam int REFRAC_OFF = LEAK_OFF + LEAK_W;
  localparam int LEN        = REFRAC_OFF + REFRAC_W;
  localparam int SW         = V_WIDTH + 3;

  logic [LEN-1:0]      cfg_word;
  logic [V_WIDTH-1:0]  thr;
  logic [LEAK_W-1:0]   leak;
  logic [REFRAC_W-1:0] refrac;

  logic [V_WIDTH-1:0]  v;
  logic [REFRAC_W-1:0] rcnt;

  logic [SW-1:0]       acc;
  logic [V_WIDTH-1:0]  vn;
  logic                fire;

  fpna_cfg_chain #(
    .LEN(LEN)
  ) u_cfg_chain (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_en  (cfg_en),
    .cfg_in  (cfg_in),
    .cfg_word(cfg_word),
    .cfg_out (cfg_out)
  );

  // Fields are decoded live; they churn while the chain shifts, which is harmless
  assign thr    = cfg_word[THR_OFF +: V_WIDTH];
  assign leak   = cfg_word[LEAK_OFF +: LEAK_W];
  assign refrac = cfg_word[REFRAC_OFF +: REFRAC_W];

  // Two's complement sum at SW bits: MSB set means negative, bits above V_WIDTH mean overflow
  always_comb begin
    acc = {{(SW-V_WIDTH){1'b0}}, v};
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) begin
        acc = acc + {{(SW-W_WIDTH){cfg_word[i*W_WIDTH + W_WIDTH-1]}},
                     cfg_word[i*W_WIDTH +: W_WIDTH]};
      end
    end
    acc = acc - {{(SW-LEAK_W){1'b0}}, leak};

    if (acc[SW-1]) begin
      vn = '0;
    end else if (|acc[SW-2:V_WIDTH]) begin
      vn = '1;
    end else begin
      vn = acc[V_WIDTH-1:0];
    end

    fire = (thr != '0) && (vn >= thr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v         <= '0;
      rcnt      <= '0;
      spike_out <= 1'b0;
    end else if (cfg_en) begin
      v         <= '0;
      rcnt      <= '0;
      spike_out <= 1'b0;
    end else if (!ena) begin
      spike_out <= 1'b0;
    end else if (rcnt != '0) begin
      rcnt      <= rcnt - 1'b1;
      v         <= '0;
      spike_out <= 1'b0;
    end else if (fire) begin
      v         <= '0;
      rcnt      <= refrac;
      spike_out <= 1'b1;
    end else begin
      v         <= vn;
      spike_out <= 1'b0;
    end
  end

  assign v_mem = v;

endmodule
